// File: rtl/demux_1x4_4b_reg_if.sv
// Bus bundle for the registered 1-to-4 word distributor.
// The producer side (in_*, mode) and the four consumer lanes (out*, out_valid,
// out_ready) share one interface. The environment drives it through 'master',
// and the distributor drives it through 'slave'.
interface demux_1x4_4b_reg_if #(
  parameter int WIDTH = 4
);

  // Producer side
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic             mode;

  // Consumer lanes
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;

  // Status
  logic [1:0]       rr_ptr;

  // Producer and consumers: they drive the requests and sample the lanes.
  modport master (
    output in_data,
    output in_valid,
    output in_sel,
    output mode,
    output out_ready,
    input  in_ready,
    input  out0,
    input  out1,
    input  out2,
    input  out3,
    input  out_valid,
    input  rr_ptr
  );

  // Distributor: it accepts words and presents the lane registers.
  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sel,
    input  mode,
    input  out_ready,
    output in_ready,
    output out0,
    output out1,
    output out2,
    output out3,
    output out_valid,
    output rr_ptr
  );

endinterface

// File: rtl/demux_1x4_4b_reg.sv
// Registered 1-to-4 distributor for WIDTH-bit words.
// One producer stream is steered into one of four lane registers. The target
// lane comes from in_sel (mode=0) or from an internal round-robin pointer
// (mode=1). Each lane is a single-entry buffer with its own valid/ready
// handshake. A lane can be drained and refilled on the same edge, so every
// lane can sustain one word per cycle.
module demux_1x4_4b_reg #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_1x4_4b_reg_if.slave      bus
);

  // Lane storage and occupancy
  logic [WIDTH-1:0] lane_q [4];
  logic [3:0]       full_q;
  logic [1:0]       rr_ptr_q;

  // Per-cycle decisions
  logic [1:0]       tgt;
  logic             in_ready;
  logic             accept;
  logic [3:0]       fill;
  logic [3:0]       drain;

  // Target lane, ready and per-lane fill/drain strobes. All of these are
  // combinational and are evaluated every cycle.
  always_comb begin
    // NOTE: each variable gets a default before any branch. If a path left one
    // unassigned, the tools would infer a latch.
    tgt      = bus.in_sel;
    in_ready = 1'b0;
    accept   = 1'b0;
    fill     = '0;
    drain    = '0;

    if (bus.mode) begin
      tgt = rr_ptr_q;
    end

    // Ready looks only at the target lane. It is masked during reset so that
    // the producer never sees a handshake that the reset would discard.
    in_ready = !rst && (!full_q[tgt] || bus.out_ready[tgt]);
    accept   = bus.in_valid && in_ready;

    if (accept) begin
      fill[tgt] = 1'b1;
    end

    // A consumer's ready on an empty lane is ignored, because of the &full_q.
    drain = full_q & bus.out_ready;
  end

  // Lane registers, occupancy bits and the round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // then samples pre-edge values, whatever order the statements are in.
    if (rst) begin
      // NOTE: the lane data registers are reset too, not only the valid bits.
      // Outputs must read 0 after reset and must never carry X downstream.
      for (int k = 0; k < 4; k++) begin
        lane_q[k] <= '0;
      end
      full_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (fill[k]) begin
          // A refill has priority over a drain on the same edge. The new word
          // replaces the old one and the lane stays full.
          lane_q[k] <= bus.in_data;
          full_q[k] <= 1'b1;
        end else if (drain[k]) begin
          // The data is left stale on purpose; only the valid bit drops.
          full_q[k] <= 1'b0;
        end
      end

      // The pointer moves only when a round-robin word is accepted. It keeps its
      // value in explicit mode, so a return to mode=1 resumes at the same lane.
      if (accept && bus.mode) begin
        rr_ptr_q <= rr_ptr_q + 2'd1;
      end
    end
  end

  // Drive the outputs from the registered state.
  assign bus.in_ready  = in_ready;
  assign bus.out0      = lane_q[0];
  assign bus.out1      = lane_q[1];
  assign bus.out2      = lane_q[2];
  assign bus.out3      = lane_q[3];
  assign bus.out_valid = full_q;
  assign bus.rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux_1x4_4b_reg.sv
// Directed bench for the registered 1-to-4 distributor.
// Inputs change 1 time unit after a rising edge. Combinational and registered
// outputs are sampled in the middle of the cycle, well away from either edge.
module tb_demux_1x4_4b_reg;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  demux_1x4_4b_reg_if #(.WIDTH(WIDTH)) bus ();

  demux_1x4_4b_reg #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed=no summary expected=summary before time limit");
    $fatal(1, "time limit reached");
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock. Inputs then settle 1 unit after the edge, and sampling
  // happens at mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Read lane k's data register.
  function automatic logic [WIDTH-1:0] lane(input int k);
    case (k)
      0:       return bus.out0;
      1:       return bus.out1;
      2:       return bus.out2;
      default: return bus.out3;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;

    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.mode      = 1'b0;
    bus.out_ready = 4'b0000;

    // ---- Reset ----
    step();
    rst = 1'b0;
    settle();
    check("reset out_valid", 32'(bus.out_valid), 32'h0);
    check("reset out0", 32'(bus.out0), 32'h0);
    check("reset out1", 32'(bus.out1), 32'h0);
    check("reset out2", 32'(bus.out2), 32'h0);
    check("reset out3", 32'(bus.out3), 32'h0);
    check("reset rr_ptr", 32'(bus.rr_ptr), 32'h0);
    check("reset in_ready", 32'(bus.in_ready), 32'h1);

    // ---- Explicit routing: A to lane 2 ----
    bus.mode     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_data  = 4'hA;
    settle();
    check("route in_ready before", 32'(bus.in_ready), 32'h1);
    step();
    bus.in_valid = 1'b0;
    settle();
    check("route out2", 32'(bus.out2), 32'hA);
    check("route out_valid", 32'(bus.out_valid), 32'h4);
    check("route rr_ptr", 32'(bus.rr_ptr), 32'h0);
    check("route in_ready sel2", 32'(bus.in_ready), 32'h0);
    bus.in_sel = 2'd0;
    settle();
    check("route in_ready sel0", 32'(bus.in_ready), 32'h1);

    // ---- Backpressure hold on lane 2, then drain and refill on one edge ----
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_data  = 4'h5;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp in_ready", 32'(bus.in_ready), 32'h0);
      step();
      check("bp out2 hold", 32'(bus.out2), 32'hA);
      check("bp out_valid", 32'(bus.out_valid), 32'h4);
    end
    bus.out_ready = 4'b0100;
    settle();
    check("bp release in_ready", 32'(bus.in_ready), 32'h1);
    step();
    bus.in_valid = 1'b0;
    settle();
    check("bp refill out2", 32'(bus.out2), 32'h5);
    check("bp refill out_valid", 32'(bus.out_valid), 32'h4);
    step();
    bus.out_ready = 4'b0000;
    settle();
    check("drain out_valid", 32'(bus.out_valid), 32'h0);
    check("drain out2 stale", 32'(bus.out2), 32'h5);

    // ---- Round-robin wrap: words 1..5 back to back ----
    bus.mode      = 1'b1;
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data = WIDTH'(i);
      settle();
      check("rr ptr before", 32'(bus.rr_ptr), 32'((i - 1) % 4));
      check("rr in_ready", 32'(bus.in_ready), 32'h1);
      step();
      settle();
      check("rr lane data", 32'(lane((i - 1) % 4)), 32'(i));
      check("rr out_valid", 32'(bus.out_valid), 32'(1 << ((i - 1) % 4)));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    settle();
    check("rr ptr after wrap", 32'(bus.rr_ptr), 32'h1);

    // ---- Round-robin stall: fill lane 1 in explicit mode, then stall on it ----
    bus.mode     = 1'b0;
    bus.in_sel   = 2'd1;
    bus.in_data  = 4'h6;
    bus.in_valid = 1'b1;
    step();
    settle();
    check("stall fill out_valid", 32'(bus.out_valid), 32'h3);
    check("stall ptr held mode0", 32'(bus.rr_ptr), 32'h1);
    bus.mode    = 1'b1;
    bus.in_data = 4'h9;
    settle();
    check("stall in_ready", 32'(bus.in_ready), 32'h0);
    step();
    settle();
    check("stall ptr held", 32'(bus.rr_ptr), 32'h1);
    check("stall out1 hold", 32'(bus.out1), 32'h6);
    bus.out_ready = 4'b0010;
    settle();
    check("stall release in_ready", 32'(bus.in_ready), 32'h1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    settle();
    check("stall release out1", 32'(bus.out1), 32'h9);
    check("stall release ptr", 32'(bus.rr_ptr), 32'h2);
    check("stall release out_valid", 32'(bus.out_valid), 32'h3);

    // ---- Parallel drain of lanes 0 and 3 while lane 1 is filled ----
    bus.out_ready = 4'b0011;
    step();
    bus.out_ready = 4'b0000;
    settle();
    check("pd empty", 32'(bus.out_valid), 32'h0);
    bus.mode     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    bus.in_data  = 4'h3;
    step();
    bus.in_sel  = 2'd3;
    bus.in_data = 4'hC;
    step();
    settle();
    check("pd setup out_valid", 32'(bus.out_valid), 32'h9);
    bus.out_ready = 4'b1001;
    bus.in_sel    = 2'd1;
    bus.in_data   = 4'h7;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    settle();
    check("pd out_valid", 32'(bus.out_valid), 32'h2);
    check("pd out1", 32'(bus.out1), 32'h7);
    check("pd out0 stale", 32'(bus.out0), 32'h3);
    check("pd out3 stale", 32'(bus.out3), 32'hC);

    // ---- Reset mid-operation: all lanes full, pointer at 3 ----
    bus.mode     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hD;
    step();
    bus.mode    = 1'b0;
    bus.in_sel  = 2'd0;
    bus.in_data = 4'h1;
    step();
    bus.in_sel  = 2'd3;
    bus.in_data = 4'h2;
    step();
    settle();
    check("mr setup out_valid", 32'(bus.out_valid), 32'hF);
    check("mr setup ptr", 32'(bus.rr_ptr), 32'h3);
    check("mr setup out2", 32'(bus.out2), 32'hD);
    // With out_ready[0] high, the word would be accepted if reset did not win.
    rst           = 1'b1;
    bus.in_sel    = 2'd0;
    bus.in_data   = 4'hF;
    bus.out_ready = 4'b0001;
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    settle();
    check("mr out_valid", 32'(bus.out_valid), 32'h0);
    check("mr out0", 32'(bus.out0), 32'h0);
    check("mr out1", 32'(bus.out1), 32'h0);
    check("mr out2", 32'(bus.out2), 32'h0);
    check("mr out3", 32'(bus.out3), 32'h0);
    check("mr rr_ptr", 32'(bus.rr_ptr), 32'h0);
    check("mr in_ready", 32'(bus.in_ready), 32'h1);
    step();
    settle();
    check("mr no accept", 32'(bus.out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_1x4_4b_reg.md
Name: demux_1x4_4b_reg

Overview:
- Registered 1-to-4 distributor for 4-bit words. It is the inverse of the 4-bit 4x1 mux datapath.
- One input stream is steered into one of four output lane registers. Each lane has its own valid/ready handshake.
- Lane selection is either explicit (select input) or round-robin (internal pointer).
- Sits in front of four consumers that share one producer, e.g. a register bank or four ALU operand slots.

Parameters:
WIDTH, 4, data width of input word and each lane register

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_data  input  WIDTH  word to distribute
in_valid  input  1  producer has a word this cycle
in_ready  output  1  block accepts in_data this cycle (combinational)
in_sel  input  2  target lane when mode=0
mode  input  1  0 = explicit select via in_sel, 1 = round-robin pointer
out0, out1, out2, out3  output  WIDTH each  lane data registers
out_valid  output  4  bit k = lane k holds a word
out_ready  input  4  bit k = consumer k takes lane k this cycle
rr_ptr  output  2  current round-robin pointer (status)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge.
- Reset values: out0..out3 = 0, out_valid = 4'b0000, rr_ptr = 0.
  - In the cycle after reset, in_ready = 1 because all lanes are empty.
- Reset mid-operation discards all held words. No handshake completes in a cycle where rst=1.
- Target lane: t = mode ? rr_ptr : in_sel. Combinational, evaluated every cycle. A mode change takes effect the same cycle.
- Ready rule: in_ready = !out_valid[t] || out_ready[t].
  - Depends only on the target lane; the other lanes' state is irrelevant.
  - in_ready may be high while in_valid=0.
- Accept: in_valid && in_ready at the clock edge.
  - out_t <= in_data and out_valid[t] <= 1.
  - Latency 1 cycle: the word is visible on out_t the cycle after acceptance.
- Drain: out_valid[k] && out_ready[k], with lane k not being refilled this edge.
  - out_valid[k] <= 0. out_k keeps its stale value; there is no clearing.
- Simultaneous drain and fill of the same lane: the new word replaces the old one and out_valid[t] stays 1. Full throughput is 1 word/cycle per lane.
- Independent lanes: drains on non-target lanes proceed in parallel with an accept on the target lane.
- Hold: while out_valid[k]=1 and out_ready[k]=0, out_k is stable.
- Stall: in_valid=1 with in_ready=0 leaves all state unchanged. The producer must hold in_data/in_sel.
- Round-robin pointer:
  - Advances only on an accept with mode=1: rr_ptr <= rr_ptr+1 mod 4, wrapping 3 -> 0.
  - Holds in mode 0 and on stalls. It is not reset on a mode change.
- out_ready[k] while out_valid[k]=0 is ignored.
- in_data, in_sel and mode are ignored when in_valid=0, except that in_ready still reflects t.
- No internal FSM beyond per-lane full/empty bits and the pointer. No X propagation on outputs after reset.

Test Plan:
- Reset then explicit routing: rst 1 cycle; mode=0, in_valid=1, sel=2, in_data=4'hA, out_ready=0 -> next cycle out2=A, out_valid=4'b0100, rr_ptr=0; in_ready=0 for sel=2 and 1 for sel=0.
- Backpressure hold: lane 2 full (A), out_ready=0, in_valid=1, sel=2, data=5 for 3 cycles -> in_ready=0 throughout and out2 stays A; then out_ready[2]=1 -> same edge accepts 5, out2=5, out_valid[2] stays 1.
- Round-robin wrap: mode=1, out_ready=4'b1111, stream 1,2,3,4,5 back-to-back -> out0=1, out1=2, out2=3, out3=4, out0=5 on successive cycles; rr_ptr sequence 0,1,2,3,0,1.
- Round-robin stall: mode=1, rr_ptr=1, lane1 full, out_ready[1]=0 -> in_ready=0 and rr_ptr stays 1; releasing out_ready[1] accepts the word and rr_ptr becomes 2.
- Parallel drain: lanes 0 and 3 full, out_ready=4'b1001, accept 4'h7 to lane 1 same cycle -> out_valid goes 4'b1001 -> 4'b0010, out1=7.
- Reset mid-operation: all lanes full, rr_ptr=3, assert rst with in_valid=1 -> out_valid=0, outs=0, rr_ptr=0, no word accepted.
